// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encodings, the bubble (NOP) encoding and a width helper.
package hazard_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

  // A NOP is the all-zero word at whatever width the datapath uses.
  localparam logic NOP_BIT = 1'b0;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bubble_mux.sv
// Selects the decoded ID word or a NOP bubble into the ID/EX register.
module bubble_mux
  import hazard_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              sel_nop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  assign dout = sel_nop ? {DATA_W{NOP_BIT}} : din;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / multi-cycle stall controller between IF/ID and ID/EX, with a
// saturating stall-cycle counter for performance measurement.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] id_instr,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_mc_start,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic [DATA_W-1:0] idex_instr,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int               MCW      = clog2(MC_LAT + 1);
  localparam logic [MCW-1:0]   MC_INIT  = MCW'(MC_LAT - 1);
  localparam logic             MC_MULTI = (MC_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  hz_state_e        state_q, state_d;
  logic [MCW-1:0]   mc_left_q, mc_left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_hz;
  logic busy;
  logic stall;
  logic bubble;

  assign load_hz = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign busy    = (state_q == MC_BUSY);

  // A taken branch makes the ID instruction wrong-path, so a load-use stall
  // on it is pointless; an in-flight multi-cycle op still holds the pipe.
  assign stall   = busy || (load_hz && !ex_branch_taken);
  assign bubble  = stall || ex_branch_taken || !rst_n;

  assign pc_we      = rst_n && !stall;
  assign ifid_we    = rst_n && !stall;
  assign ifid_flush = ex_branch_taken || !rst_n;
  assign mc_busy    = busy;
  assign stall_cnt  = stall_cnt_q;

  bubble_mux #(
    .DATA_W(DATA_W)
  ) u_bubble_mux (
    .sel_nop(bubble),
    .din    (id_instr),
    .dout   (idex_instr)
  );

  always_comb begin
    state_d     = state_q;
    mc_left_d   = mc_left_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      IDLE: begin
        if (id_mc_start && !load_hz && !ex_branch_taken && MC_MULTI) begin
          state_d   = MC_BUSY;
          mc_left_d = MC_INIT;
        end
      end
      MC_BUSY: begin
        if (mc_left_q <= MCW'(1)) begin
          state_d   = IDLE;
          mc_left_d = '0;
        end else begin
          mc_left_d = mc_left_q - MCW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mc_left_d = '0;
      end
    endcase

    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mc_left_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_left_q   <= mc_left_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: three instances share one stimulus
// (MC_LAT=4, MC_LAT=1, and a 2-bit counter for saturation).
module tb_hazard_stall_unit;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [DATA_W-1:0] INSTR = 32'h1234_5678;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] id_instr;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              id_mc_start;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_branch_taken;

  logic              pc_we_a, ifid_we_a, ifid_flush_a, mc_busy_a;
  logic [DATA_W-1:0] idex_a;
  logic [15:0]       cnt_a;
  logic              pc_we_b, ifid_we_b, ifid_flush_b, mc_busy_b;
  logic [DATA_W-1:0] idex_b;
  logic [15:0]       cnt_b;
  logic              pc_we_c, ifid_we_c, ifid_flush_c, mc_busy_c;
  logic [DATA_W-1:0] idex_c;
  logic [1:0]        cnt_c;

  int n_tests;
  int n_fail;

  hazard_stall_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MC_LAT(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_mc_start(id_mc_start), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .pc_we(pc_we_a),
    .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a), .idex_instr(idex_a),
    .mc_busy(mc_busy_a), .stall_cnt(cnt_a));

  hazard_stall_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MC_LAT(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_mc_start(id_mc_start), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .pc_we(pc_we_b),
    .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b), .idex_instr(idex_b),
    .mc_busy(mc_busy_b), .stall_cnt(cnt_b));

  hazard_stall_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MC_LAT(4), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_mc_start(id_mc_start), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .pc_we(pc_we_c),
    .ifid_we(ifid_we_c), .ifid_flush(ifid_flush_c), .idex_instr(idex_c),
    .mc_busy(mc_busy_c), .stall_cnt(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    id_instr        = INSTR;
    id_rs           = 5'd1;
    id_rt           = 5'd2;
    id_uses_rt      = 1'b0;
    id_mc_start     = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rt           = 5'd0;
    ex_branch_taken = 1'b0;
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_in();
    rst_n       = 1'b0;
    ex_mem_read = 1'b1;
    ex_rt       = 5'd8;
    id_rs       = 5'd8;
    #2;
    check("rst_pc_we",   pc_we_a,      1'b0);
    check("rst_ifid_we", ifid_we_a,    1'b0);
    check("rst_flush",   ifid_flush_a, 1'b1);
    check("rst_idex",    idex_a,       '0);
    check("rst_busy",    mc_busy_a,    1'b0);
    check("rst_cnt",     cnt_a,        '0);
    tick();
    idle_in();
    rst_n = 1'b1;

    tick();
    check("pass_pc_we", pc_we_a,      1'b1);
    check("pass_ifid",  ifid_we_a,    1'b1);
    check("pass_flush", ifid_flush_a, 1'b0);
    check("pass_idex",  idex_a,       INSTR);

    // Load-use on rs
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    check("lu_pc_we", pc_we_a,   1'b0);
    check("lu_ifid",  ifid_we_a, 1'b0);
    check("lu_idex",  idex_a,    '0);
    check("lu_flush", ifid_flush_a, 1'b0);
    tick();
    idle_in();
    #1;
    check("lu_after_idex", idex_a,  INSTR);
    check("lu_after_pc",   pc_we_a, 1'b1);
    check("lu_cnt",        cnt_a,   16'd1);

    // rt match gated by id_uses_rt
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    check("rt_unused_pc", pc_we_a, 1'b1);
    id_uses_rt = 1'b1;
    #1;
    check("rt_used_pc", pc_we_a, 1'b0);
    tick();

    // Register 0 never hazards
    idle_in();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    check("r0_pc_we", pc_we_a, 1'b1);
    check("r0_cnt",   cnt_a,   16'd2);
    tick();

    // Flush cancels load-use stall
    idle_in();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
    #1;
    check("fl_flush", ifid_flush_a, 1'b1);
    check("fl_pc_we", pc_we_a,      1'b1);
    check("fl_ifid",  ifid_we_a,    1'b1);
    check("fl_idex",  idex_a,       '0);
    tick();
    idle_in();
    #1;
    check("fl_cnt", cnt_a, 16'd2);

    // Multi-cycle op issued at T
    id_mc_start = 1'b1;
    #1;
    check("mc_t_pc_we", pc_we_a,   1'b1);
    check("mc_t_idex",  idex_a,    INSTR);
    check("mc_t_busy",  mc_busy_a, 1'b0);
    tick();
    id_mc_start = 1'b0;
    #1;
    check("mc_t1_busy", mc_busy_a, 1'b1);
    check("mc_t1_pc",   pc_we_a,   1'b0);
    check("mc_t1_idex", idex_a,    '0);
    check("mc1_t1_busy", mc_busy_b, 1'b0);
    check("mc1_t1_pc",   pc_we_b,   1'b1);
    tick();
    ex_branch_taken = 1'b1;
    #1;
    check("mc_t2_flush", ifid_flush_a, 1'b1);
    check("mc_t2_pc",    pc_we_a,      1'b0);
    tick();
    ex_branch_taken = 1'b0;
    #1;
    check("mc_t3_busy", mc_busy_a, 1'b1);
    tick();
    check("mc_t4_busy", mc_busy_a, 1'b0);
    check("mc_t4_pc",   pc_we_a,   1'b1);
    check("mc_t4_idex", idex_a,    INSTR);
    check("mc_cnt_a",   cnt_a,     16'd5);
    check("mc_cnt_b",   cnt_b,     16'd2);
    check("mc_cnt_c",   cnt_c,     2'd3);

    // Asynchronous reset in the middle of MC_BUSY
    id_mc_start = 1'b1;
    tick();
    id_mc_start = 1'b0;
    #1;
    check("mr_busy_pre", mc_busy_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_pc_we", pc_we_a,      1'b0);
    check("mr_ifid",  ifid_we_a,    1'b0);
    check("mr_flush", ifid_flush_a, 1'b1);
    check("mr_idex",  idex_a,       '0);
    check("mr_busy",  mc_busy_a,    1'b0);
    check("mr_cnt",   cnt_a,        '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_post_busy", mc_busy_a, 1'b0);
    check("mr_post_pc",   pc_we_a,   1'b1);
    check("mr_post_cnt",  cnt_a,     16'd0);
    check("mr_post_cntc", cnt_c,     2'd0);

    // Back-to-back multi-cycle ops drive the 2-bit counter into saturation
    for (int k = 0; k < 3; k++) begin
      id_mc_start = 1'b1;
      tick();
      id_mc_start = 1'b0;
      tick();
      tick();
      tick();
    end
    check("sat_cnt_a", cnt_a, 16'd9);
    check("sat_cnt_c", cnt_c, 2'd3);
    check("sat_busy",  mc_busy_c, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Parametrised pipeline stall and bubble controller for the five-stage MIPS core, sitting between the IF/ID and ID/EX pipeline registers. It detects load-use hazards and multi-cycle EX operations and drives PC/IF/ID write enables. It also selects either the decoded instruction word or a NOP bubble into ID/EX, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- DATA_W, 32, instruction/control word width passed to ID/EX
- REG_AW, 5, register-address width
- MC_LAT, 4, EX occupancy of a multi-cycle op in cycles (>=1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock, rising edge; one clock only
- rst_n  in  1  reset, asynchronous and active-low
- id_instr  in  DATA_W  instruction/control word currently in ID
- id_rs  in  REG_AW  ID source register rs
- id_rt  in  REG_AW  ID source register rt
- id_uses_rt  in  1  ID instruction reads rt
- id_mc_start  in  1  ID instruction is a multi-cycle op (mult/div)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_AW  destination of the load in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_instr  out  DATA_W  word to ID/EX: id_instr or all-zero bubble
- mc_busy  out  1  multi-cycle op occupying EX
- stall_cnt  out  CNT_W  total stalled cycles, saturating

## Operation
- load_hz = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- FSM states: IDLE, MC_BUSY. Down-counter mc_left, width clog2(MC_LAT+1).
- stall = load_hz | (state == MC_BUSY).
- Under stall: pc_we=0, ifid_we=0, idex_instr=0. Otherwise pc_we=1, ifid_we=1, idex_instr=id_instr.
- ifid_flush = ex_branch_taken, regardless of stall. When flush and load_hz coincide in IDLE, the stall is cancelled: pc_we=1, ifid_we=1, idex_instr=0, because the ID instruction is wrong-path.
- IDLE -> MC_BUSY when id_mc_start & !load_hz & !ex_branch_taken & MC_LAT>1; mc_left loads MC_LAT-1. The issuing cycle itself is not stalled.
- MC_BUSY: mc_left decrements each cycle. The state returns to IDLE in the cycle after mc_left reaches 1. ex_branch_taken still asserts ifid_flush but does not shorten MC_BUSY.
- id_mc_start is ignored while in MC_BUSY.
- mc_busy = (state == MC_BUSY).
- stall_cnt increments by 1 on every clock where stall=1 after flush cancellation, and saturates at 2^CNT_W-1.
- Register addresses are compared as full REG_AW-bit unsigned values. Register 0 never causes a hazard.

## Timing
- Hazard outputs are combinational from inputs and state, with zero latency: a stall is visible in the same cycle as the hazard.
- A load-use stall lasts exactly 1 cycle, because the injected bubble clears ex_mem_read on the next cycle.
- A multi-cycle op issued at cycle T gives stall=1 in cycles T+1 .. T+MC_LAT-1, with the next instruction advancing at T+MC_LAT.
- Reset (rst_n=0, asynchronous, any time including mid-MC_BUSY):
  - state=IDLE, mc_left=0, stall_cnt=0, mc_busy=0.
  - While rst_n=0: pc_we=0, ifid_we=0, ifid_flush=1, idex_instr=0.
- First normal cycle is the first rising edge after rst_n deasserts.

## Structure
- Shared package hazard_pkg holds:
  - state encodings IDLE/MC_BUSY
  - the NOP encoding (all-zero, DATA_W wide)
  - a clog2 helper function
- One natural sub-module: bubble_mux (DATA_W-parameterised 2:1 select of id_instr/NOP under stall|flush). Everything else is inline.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> pc_we=0, ifid_we=0, idex_instr=0 for 1 cycle, then pass-through; stall_cnt=1.
- rt-only and zero-register cases:
  - ex_rt=9=id_rt with id_uses_rt=0 -> no stall.
  - ex_rt=0=id_rs -> no stall.
- Multi-cycle with MC_LAT=4: id_mc_start at T -> mc_busy and stall high in T+1..T+3, pass-through at T+4; stall_cnt=3. With MC_LAT=1: no stall.
- Flush vs load hazard: load_hz and ex_branch_taken in the same cycle -> ifid_flush=1, pc_we=1, idex_instr=0, stall_cnt unchanged.
- Reset mid-MC_BUSY: assert rst_n=0 between edges -> outputs go to reset values immediately. After release, the block is in IDLE with stall_cnt=0.
- Saturation: CNT_W=2 with a long sequence of multi-cycle ops -> stall_cnt holds at 3.
